rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//   Parametrised N-channel round-robin arbitrating multiplexer with valid/ready handshake.
//   Successor to the fixed 4:1 combinational operand mux: width and channel count are generic.
//   Adds a registered output stage and fair arbitration.
//   Sits in the core where several requesters share one port, e.g. fetch/LSU/debug into the
//   memory interface, or multi-source writeback into the register file.
// PARAMETERS
//   DATA_W   riscv_pkg::XLEN  width of each data channel
//   N_CH     4                number of input channels (>=1)
//   SEL_W    (localparam)     max(1,$clog2(N_CH)); width of out_sel
// PORTS
//   clk        in   1              single clock; all state updates on posedge
//   rst        in   1              synchronous, active-high reset
//   in_valid   in   N_CH           per-channel request valid
//   in_data    in   N_CH*DATA_W    per-channel data; channel i at [i*DATA_W +: DATA_W]
//   in_ready   out  N_CH           per-channel accept; one-hot or zero
//   out_valid  out  1              output register holds a beat
//   out_data   out  DATA_W         data of the held beat
//   out_sel    out  SEL_W          channel index the held beat came from
//   out_ready  in   1              downstream accept
//   in_lock    in   N_CH           only present when RR_ARB_MUX_LOCK_EN is defined
// BEHAVIOUR
//   - Reset (sync, rst=1 at posedge): out_valid=0, out_data=0, out_sel=0, last_grant=N_CH-1,
//     lock flag=0. in_ready=0 while rst=1. A pending beat is dropped.
//   - load_en = !out_valid | out_ready. The output register is a single slot. Throughput is
//     1 beat/cycle. Latency is 1 cycle from in_valid&in_ready to out_valid.
//   - Winner: the first channel with in_valid=1, searching last_grant+1, +2, ... modulo N_CH.
//     The search is combinational.
//   - in_ready[w]=1 only when load_en and w is the winner. All other bits of in_ready are 0.
//   - Transfer at posedge when in_valid[w]&in_ready[w]:
//     out_data<=in_data[w], out_sel<=w, out_valid<=1, last_grant<=w.
//   - No transfer and out_ready=1: out_valid<=0. out_data and out_sel hold their last values.
//   - Backpressure: when out_valid=1 and out_ready=0, out_valid, out_data and out_sel stay
//     stable, and in_ready=0 for every channel.
//   - All channels valid: grants rotate strictly 0,1,...,N_CH-1,0,...
//   - A single active requester is granted on consecutive cycles with no bubble.
//   - Upstream holds in_valid and in_data until in_ready. The block does not depend on this
//     for its own correctness.
//   - N_CH=1: the block degenerates to a one-slot pipeline register. out_sel is always 0.
//   - last_grant wraps from N_CH-1 to 0. N_CH that is not a power of two is supported; out_sel
//     never exceeds N_CH-1.
// CONFIGURATION
//   RR_ARB_MUX_LOCK_EN defined:
//   - Adds the in_lock port.
//   - If a beat transfers with in_lock[w]=1, the lock flag is set and the locked channel is w.
//   - While the lock flag is set, only channel w may win. Other channels see in_ready=0 even if
//     channel w is idle.
//   - A transfer from w with in_lock[w]=0 clears the lock flag.
//   - rst clears the lock flag.
//   RR_ARB_MUX_LOCK_EN undefined: no in_lock port and no lock state. The block is pure
//   round-robin.
// TESTING (DATA_W=32, N_CH=4)
//   1. Reset: rst=1 for 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0.
//      First grant after reset is channel 0.
//   2. Rotation: all valid, data 0xA0..0xA3, out_ready=1 -> out_sel 0,1,2,3,0 on consecutive
//      cycles, out_data matching. First beat one cycle after reset release.
//   3. Single requester: only ch2 valid for 5 beats -> 5 back-to-back beats with out_sel=2 and
//      no gaps.
//   4. Backpressure: out_ready=0 for 3 cycles while out_sel=1 -> out_data and out_sel stable,
//      in_ready=0. Then out_ready=1 -> next beat is from ch2.
//   5. Reset mid-stream: rst pulsed while out_valid=1 -> next cycle out_valid=0. Rotation
//      restarts at ch0.
//   6. Lock (macro on): all valid, ch1 in_lock=1 for 3 beats then 0 -> out_sel 0,1,1,1,1,2.
//      ch0/ch2/ch3 in_ready=0 while locked.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with a registered one-slot output stage.
// Define RR_ARB_MUX_LOCK_EN to add per-channel in_lock (grant stays on a locked channel).
package riscv_pkg;
    localparam int XLEN = 32;
endpackage

module rr_arb_mux #(
    parameter  int DATA_W = riscv_pkg::XLEN,
    parameter  int N_CH   = 4,
    localparam int SEL_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [N_CH-1:0]        in_lock,
`endif
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    input  logic                   out_ready
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  r_last;
`ifdef RR_ARB_MUX_LOCK_EN
    logic              r_lock;
`endif

    logic              w_load;
    logic              w_found;
    logic [SEL_W-1:0]  w_win;
    logic              w_xfer;

    assign w_load = !r_valid || out_ready;

    // Descending scan so the nearest channel after last_grant is written last.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = N_CH; k >= 1; k--) begin
            int idx;
            idx = (int'(r_last) + k) % N_CH;
            if (in_valid[idx]) begin
                w_found = 1'b1;
                w_win   = SEL_W'(idx);
            end
        end
`ifdef RR_ARB_MUX_LOCK_EN
        // A locked channel is always the last granted one.
        if (r_lock) begin
            w_found = in_valid[r_last];
            w_win   = r_last;
        end
`endif
    end

    assign w_xfer = w_found && w_load && !rst;

    always_comb begin
        in_ready = '0;
        if (w_xfer)
            in_ready = N_CH'(1) << w_win;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_last  <= SEL_W'(N_CH - 1);
`ifdef RR_ARB_MUX_LOCK_EN
            r_lock  <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= in_data[w_win*DATA_W +: DATA_W];
            r_sel   <= w_win;
            r_last  <= w_win;
`ifdef RR_ARB_MUX_LOCK_EN
            r_lock  <= in_lock[w_win];
`endif
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (DATA_W=32, N_CH=4).
// Lock scenario runs only when RR_ARB_MUX_LOCK_EN is defined.
module tb_rr_arb_mux;

    localparam int DW = 32;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] in_valid;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0] in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_ready;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [NC-1:0] in_lock;
`endif

    int total = 0;
    int bad   = 0;

    rr_arb_mux #(.DATA_W(DW), .N_CH(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_lock   (in_lock),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int sel, input int dat);
        step();
        chk({tag, ".v"}, 64'(out_valid), 64'd1);
        chk({tag, ".s"}, 64'(out_sel), 64'(sel));
        chk({tag, ".d"}, 64'(out_data), 64'(dat));
    endtask

    task automatic set_std_data();
        for (int i = 0; i < NC; i++)
            in_data[i*DW +: DW] = DW'(32'hA0 + i);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        set_std_data();
`ifdef RR_ARB_MUX_LOCK_EN
        in_lock   = '0;
`endif
        // Reset with all requesters active
        step();
        step();
        chk("rst.rdy",  64'(in_ready),  64'h0);
        chk("rst.v",    64'(out_valid), 64'h0);
        chk("rst.d",    64'(out_data),  64'h0);
        chk("rst.s",    64'(out_sel),   64'h0);
        rst = 1'b0;
        #1;
        chk("first.rdy", 64'(in_ready), 64'h1);

        // Rotation
        for (int i = 0; i < 5; i++)
            beat($sformatf("rot%0d", i), i % NC, 32'hA0 + (i % NC));

        // Single requester ch2, back-to-back
        in_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            in_data[2*DW +: DW] = DW'(32'hB0 + k);
            beat($sformatf("single%0d", k), 2, 32'hB0 + k);
        end
        set_std_data();

        // Get ch1 into the output, then stall
        in_valid = 4'b0010;
        beat("pre_bp", 1, 32'hA1);
        in_valid  = 4'hF;
        out_ready = 1'b0;
        #1;
        chk("bp.rdy0", 64'(in_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp%0d.v", k), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d.s", k), 64'(out_sel),   64'd1);
            chk($sformatf("bp%0d.d", k), 64'(out_data),  64'hA1);
            chk($sformatf("bp%0d.rdy", k), 64'(in_ready), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.rel.rdy", 64'(in_ready), 64'h4);
        beat("bp.next", 2, 32'hA2);

        // Mid-stream reset
        rst = 1'b1;
        step();
        chk("mrst.v", 64'(out_valid), 64'h0);
        chk("mrst.s", 64'(out_sel),   64'h0);
        chk("mrst.rdy", 64'(in_ready), 64'h0);
        rst = 1'b0;
        beat("mrst.b0", 0, 32'hA0);
        beat("mrst.b1", 1, 32'hA1);

        // Idle with out_ready drains the slot
        in_valid = 4'h0;
        step();
        chk("drain.v", 64'(out_valid), 64'h0);
        chk("drain.s", 64'(out_sel),   64'h1);

`ifdef RR_ARB_MUX_LOCK_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 4'hF;
        in_lock  = 4'b0010;
        beat("lk0", 0, 32'hA0);
        beat("lk1", 1, 32'hA1);
        chk("lk1.rdy", 64'(in_ready), 64'h2);
        beat("lk2", 1, 32'hA1);
        chk("lk2.rdy", 64'(in_ready), 64'h2);
        beat("lk3", 1, 32'hA1);
        in_lock = 4'b0000;
        #1;
        chk("lk3.rdy", 64'(in_ready), 64'h2);
        beat("lk4", 1, 32'hA1);
        chk("lk4.rdy", 64'(in_ready), 64'h4);
        beat("lk5", 2, 32'hA2);
        // Locked channel idle: others still blocked
        in_lock = 4'b1000;
        beat("lk6", 3, 32'hA3);
        in_valid = 4'b0111;
        #1;
        chk("lk.idle.rdy", 64'(in_ready), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
